// File: rtl/pc_unit_pkg.sv
// Shared encodings and defaults for the program-counter unit.
package pc_unit_pkg;

  // Next-PC selection codes driven by the multi-cycle controller.
  typedef enum logic [2:0] {
    NPC_SEQ    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JR     = 3'd3,
    NPC_RAS    = 3'd4,
    NPC_ERET   = 3'd5
  } npc_sel_e;

  // Control state of the PC unit.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXC  = 2'd2
  } pc_state_e;

  localparam logic [31:0] TEXT_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  // Word alignment check on the two low address bits.
  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return (lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO. A push when full overwrites the
// oldest entry; a pop when empty is ignored; push+pop replaces the top.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;   // next free slot
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign top_idx = ptr_q - 1'b1;
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));

  // Next stack contents, pointer and occupancy.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push && pop && !empty) begin
      mem_d[top_idx] = din;
    end else if (push) begin
      mem_d[ptr_q] = din;
      ptr_d        = ptr_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC/EPC registers, next-PC selection, exception
// entry/return, misaligned-target trapping and return-address prediction.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] TEXT_BASE  = WIDTH'(TEXT_BASE_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF),
  parameter int               RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_wr,
  input  logic [2:0]       npc_sel,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             push_ra,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             in_exc,
  output logic             fetch_valid,
  output logic             misalign,
  output logic             ras_empty,
  output logic             ras_full
);

  // Handshake: pc_wr is a one-cycle-per-edge write strobe from the
  // controller; there is no back-pressure, an update is taken on every edge
  // where it is high unless an exception or a fault preempts it.

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             misalign_q, misalign_d;

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ras_top;
  logic             exc_take, eret_sel, upd, fault, accept;
  logic             ras_push, ras_pop;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign pc       = pc_q;
  assign epc      = epc_q;
  assign misalign = misalign_q;

  // Target mux; RAS falls back to the register target when the stack is empty.
  always_comb begin
    target = pc_plus4;
    case (npc_sel)
      NPC_SEQ:    target = pc_plus4;
      NPC_BRANCH: target = branch_target;
      NPC_JUMP:   target = jump_target;
      NPC_JR:     target = jr_target;
      NPC_RAS:    target = ras_empty ? jr_target : ras_top;
      NPC_ERET:   target = epc_q;
      default:    target = pc_plus4;
    endcase
  end

  // Decide what happens this edge: exception, fault, accepted update or hold.
  always_comb begin
    eret_sel = (npc_sel == NPC_ERET);
    exc_take = (state_q == ST_RUN) && exc_req;
    upd      = pc_wr && (state_q != ST_BOOT) && !exc_take &&
               !(eret_sel && (state_q == ST_RUN));
    fault    = upd && !eret_sel && is_misaligned(target[1:0]);
    accept   = upd && !fault;
    ras_push = accept && push_ra;
    ras_pop  = accept && (npc_sel == NPC_RAS);
  end

  // Next values of the PC, EPC and misalign pulse.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = fault;
    if (exc_take || fault) begin
      pc_d = EXC_VECTOR;
      // EPC is frozen while already in the handler.
      if (state_q == ST_RUN) epc_d = pc_q;
    end else if (accept) begin
      pc_d = target;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (exc_take || fault) state_d = ST_EXC;
      ST_EXC:  if (accept && eret_sel) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_BOOT;
    else      state_q <= state_d;
  end

  // FSM-derived outputs.
  always_comb begin
    in_exc      = (state_q == ST_EXC);
    fetch_valid = (state_q != ST_BOOT);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= TEXT_BASE;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        pc_wr;
  logic [2:0]  npc_sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        push_ra;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        in_exc;
  logic        fetch_valid;
  logic        misalign;
  logic        ras_empty;
  logic        ras_full;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] SEL_SEQ = 3'd0, SEL_BR = 3'd1, SEL_J = 3'd2,
                         SEL_JR = 3'd3, SEL_RAS = 3'd4, SEL_ERET = 3'd5;

  pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_wr         (pc_wr),
    .npc_sel       (npc_sel),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .push_ra       (push_ra),
    .exc_req       (exc_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .epc           (epc),
    .in_exc        (in_exc),
    .fetch_valid   (fetch_valid),
    .misalign      (misalign),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [2:0] sel, input logic ra);
    pc_wr   = wr;
    npc_sel = sel;
    push_ra = ra;
  endtask

  initial begin
    rst = 1'b0; pc_wr = 1'b0; npc_sel = SEL_SEQ; push_ra = 1'b0; exc_req = 1'b0;
    branch_target = '0; jump_target = '0; jr_target = '0;

    // 1: reset values, boot step, sequential fetch
    #12;
    check("rst_pc", pc, 32'h3000);
    check("rst_fv", fetch_valid, 0);
    check("rst_epc", epc, 0);
    check("rst_exc", in_exc, 0);
    check("rst_ras_empty", ras_empty, 1);
    check("rst_misalign", misalign, 0);
    rst = 1'b1;
    step();
    check("boot_fv", fetch_valid, 1);
    check("boot_pc", pc, 32'h3000);
    drive(1, SEL_SEQ, 0);
    step(); step(); step();
    check("seq3_pc", pc, 32'h300C);

    // 2: branch with and without write enable
    branch_target = 32'h3040;
    drive(0, SEL_BR, 0);
    step();
    check("br_nowr_pc", pc, 32'h300C);
    drive(1, SEL_BR, 0);
    step();
    check("br_pc", pc, 32'h3040);

    // 3: jal then return via RAS
    branch_target = 32'h3010;
    step();
    check("to_3010", pc, 32'h3010);
    jump_target = 32'h3100;
    drive(1, SEL_J, 1);
    step();
    check("jal_pc", pc, 32'h3100);
    check("jal_ras_nonempty", ras_empty, 0);
    drive(1, SEL_RAS, 0);
    step();
    check("ret_pc", pc, 32'h3014);
    check("ret_ras_empty", ras_empty, 1);

    // 4: overflow the RAS (pushes 3018,3104,3204,3304,3404)
    drive(1, SEL_J, 1);
    jump_target = 32'h3100; step();
    jump_target = 32'h3200; step();
    jump_target = 32'h3300; step();
    jump_target = 32'h3400; step();
    check("ras_full4", ras_full, 1);
    jump_target = 32'h3500; step();
    check("ras_full5", ras_full, 1);
    jr_target = 32'h3200;
    drive(1, SEL_RAS, 0);
    step(); check("pop1", pc, 32'h3404);
    check("pop1_notfull", ras_full, 0);
    step(); check("pop2", pc, 32'h3304);
    step(); check("pop3", pc, 32'h3204);
    step(); check("pop4", pc, 32'h3104);
    check("pop4_empty", ras_empty, 1);
    step(); check("pop5_fallback", pc, 32'h3200);

    // push and pop on the same edge replaces the top
    jump_target = 32'h3600;
    drive(1, SEL_J, 1);
    step();                               // push 3204
    check("pp_plus4", pc_plus4, 32'h3604);
    drive(1, SEL_RAS, 1);
    step();                               // pop 3204, push 3604
    check("pp_pc", pc, 32'h3204);
    check("pp_nonempty", ras_empty, 0);
    drive(1, SEL_RAS, 0);
    step();
    check("pp_pop_pc", pc, 32'h3604);
    check("pp_pop_empty", ras_empty, 1);

    // 5: misaligned JR trap, ignored nested exception, ERET
    branch_target = 32'h3020;
    drive(1, SEL_BR, 0);
    step();
    check("to_3020", pc, 32'h3020);
    jr_target = 32'h3022;
    drive(1, SEL_JR, 0);
    step();
    check("mis_pc", pc, 32'h4180);
    check("mis_epc", epc, 32'h3020);
    check("mis_pulse", misalign, 1);
    check("mis_exc", in_exc, 1);
    drive(0, SEL_SEQ, 0);
    exc_req = 1'b1;
    step();
    check("mis_pulse_end", misalign, 0);
    check("nest_epc", epc, 32'h3020);
    check("nest_pc", pc, 32'h4180);
    exc_req = 1'b0;
    drive(1, SEL_ERET, 0);
    step();
    check("eret_pc", pc, 32'h3020);
    check("eret_exc", in_exc, 0);

    // ERET outside EXC is ignored
    step();
    check("eret_run_pc", pc, 32'h3020);
    check("eret_run_exc", in_exc, 0);

    // exc_req beats pc_wr in RUN
    exc_req = 1'b1;
    drive(1, SEL_SEQ, 0);
    step();
    exc_req = 1'b0;
    check("exc_pc", pc, 32'h4180);
    check("exc_epc", epc, 32'h3020);
    check("exc_no_mis", misalign, 0);
    check("exc_in", in_exc, 1);
    drive(1, SEL_ERET, 0);
    step();
    check("exc_ret_pc", pc, 32'h3020);

    // pc+4 wraps
    jump_target = 32'hFFFF_FFFC;
    drive(1, SEL_J, 0);
    step();
    check("wrap_plus4", pc_plus4, 32'h0);
    drive(1, SEL_SEQ, 0);
    step();
    check("wrap_pc", pc, 32'h0);

    // 6: async reset mid-EXC with two RAS entries
    jump_target = 32'h3100;
    drive(1, SEL_J, 1);
    step();
    jump_target = 32'h3200;
    step();
    drive(0, SEL_SEQ, 0);
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    check("pre_rst_exc", in_exc, 1);
    check("pre_rst_epc", epc, 32'h3200);
    check("pre_rst_ras", ras_empty, 0);
    rst = 1'b0;
    #1;
    check("arst_pc", pc, 32'h3000);
    check("arst_epc", epc, 0);
    check("arst_ras", ras_empty, 1);
    check("arst_exc", in_exc, 0);
    check("arst_fv", fetch_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
